mul_seq: RTL

//  Parametrised iterative shift-add multiplier, successor of the 8-bit unsigned sequential multiplier.

---
 rtl/mul_pkg.sv | 12 +
 rtl/mul_seq_adder.sv | 10 +
 rtl/mul_seq.sv | 98 +++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared encodings for the sequential shift-add multiplier.
package mul_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_SIGN = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    SIGN = ST_SIGN
  } state_t;
endpackage

// File: rtl/mul_seq_adder.sv
// Combinational W-bit adder shared by accumulation and final negation.
module mul_seq_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);
  assign sum = a + b;
endmodule

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, signed/unsigned per operation.
module mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = 2 * WIDTH;

  state_t            state, state_nx;
  logic [WIDTH-1:0]  mcand, mplier;
  logic [CW-1:0]     cnt;
  logic [RW-1:0]     acc;
  logic              neg;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [RW-1:0]     add_a, add_b, add_sum;
  logic              last;

  // The most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
  assign a_mag = (signed_i & a_i[WIDTH-1]) ? (~a_i + WIDTH'(1)) : a_i;
  assign b_mag = (signed_i & b_i[WIDTH-1]) ? (~b_i + WIDTH'(1)) : b_i;

  assign last = (cnt == CW'(WIDTH - 1)) ||
                (EARLY_EXIT && (mplier[WIDTH-1:1] == '0));

  assign add_a = (state == SIGN) ? ~acc : acc;
  assign add_b = (state == SIGN) ? RW'(1) : (RW'(mcand) << cnt);

  mul_seq_adder #(.W(RW)) u_adder (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (last)  state_nx = SIGN;
      SIGN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          if (mplier[0]) acc <= add_sum;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
        end
        SIGN: begin
          // Negating zero wraps back to zero, so a zero product ignores neg.
          result <= neg ? add_sum : acc;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
